hack_memory: RTL and testbench

- Data-memory responder for the Hack CPU: the far end of its addressM/writeM/outM/inM interface.
- Decodes the Hack address map into RAM (16K words), screen memory (8K words) and the KBD register.
- Returns inM combinationally within the same cycle and commits writes on the clock edge.
- Also provides a registered read port into screen memory for a display scanner, and a valid/ready ingress for key codes from a keyboard decoder.

---
 rtl/hack_pkg.sv | 29 ++
 rtl/hack_kbd_fifo.sv | 50 +++++
 rtl/hack_memory.sv | 112 +++++++++++
 tb/tb_hack_memory.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hack_pkg.sv
// Shared constants, region enum and address decoder for the Hack data memory.
package hack_pkg;

    localparam logic [14:0] RAM_BASE    = 15'h0000;
    localparam logic [14:0] SCREEN_BASE = 15'h4000;
    localparam logic [14:0] KBD_ADDR    = 15'h6000;

    typedef enum logic [1:0] {
        REG_RAM,
        REG_SCREEN,
        REG_KBD,
        REG_NONE
    } region_t;

    function automatic region_t decode_addr(input logic [14:0] addr);
        region_t r;
        if (addr[14] == RAM_BASE[14]) begin
            r = REG_RAM;
        end else if (addr[14:13] == SCREEN_BASE[14:13]) begin
            r = REG_SCREEN;
        end else if (addr == KBD_ADDR) begin
            r = REG_KBD;
        end else begin
            r = REG_NONE;
        end
        return r;
    endfunction

endpackage

// File: rtl/hack_kbd_fifo.sv
// Pointer-based key-code FIFO; pushes are dropped when full, pops ignored when empty.
module hack_kbd_fifo #(
    parameter int DEPTH = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        push,
    input  logic        pop,
    input  logic [15:0] din,
    output logic        full,
    output logic        empty,
    output logic [15:0] head
);

    localparam int AW = $clog2(DEPTH);

    logic [15:0] mem [DEPTH];
    // Extra MSB on each pointer distinguishes full from empty.
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        do_push;
    logic        do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= din;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/hack_memory.sv
// Hack CPU data memory: RAM, screen, KBD with a registered display scan port.
// Define HACK_KBD_FIFO_EN to queue key codes in a FIFO popped by CPU writes to KBD.
module hack_memory
    import hack_pkg::*;
#(
    parameter int RAM_WORDS    = 16384,
    parameter int SCREEN_WORDS = 8192,
    parameter int KBD_DEPTH    = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [14:0] addressM,
    input  logic        writeM,
    input  logic [15:0] outM,
    output logic [15:0] inM,
    input  logic        kbd_valid,
    input  logic [15:0] kbd_code,
    output logic        kbd_ready,
    input  logic        scan_req,
    input  logic [12:0] scan_addr,
    output logic        scan_valid,
    output logic [15:0] scan_data,
    output logic        addr_err
);

    localparam int RAM_AW = $clog2(RAM_WORDS);
    localparam int SCR_AW = $clog2(SCREEN_WORDS);

    logic [15:0]       ram    [RAM_WORDS];
    logic [15:0]       screen [SCREEN_WORDS];
    region_t           region;
    logic [RAM_AW-1:0] ram_idx;
    logic [SCR_AW-1:0] scr_idx;
    logic [15:0]       kbd_word;

    assign region  = decode_addr(addressM);
    assign ram_idx = addressM[RAM_AW-1:0];
    assign scr_idx = addressM[SCR_AW-1:0];

    always_comb begin
        inM = '0;
        unique case (region)
            REG_RAM:    inM = ram[ram_idx];
            REG_SCREEN: inM = screen[scr_idx];
            REG_KBD:    inM = kbd_word;
            default:    inM = '0;
        endcase
    end

    // Storage is never reset, so a write coinciding with reset still lands.
    always_ff @(posedge clock) begin
        if (writeM && region == REG_RAM) begin
            ram[ram_idx] <= outM;
        end
        if (writeM && region == REG_SCREEN) begin
            screen[scr_idx] <= outM;
        end
    end

    // Scan read samples the array before this edge's CPU write (read-before-write).
    always_ff @(posedge clock) begin
        if (reset) begin
            scan_valid <= 1'b0;
            scan_data  <= '0;
            addr_err   <= 1'b0;
        end else begin
            scan_valid <= scan_req;
            if (scan_req) begin
                scan_data <= screen[scan_addr[SCR_AW-1:0]];
            end
            if (writeM && region == REG_NONE) begin
                addr_err <= 1'b1;
            end
        end
    end

`ifdef HACK_KBD_FIFO_EN
    logic        fifo_full;
    logic        fifo_empty;
    logic [15:0] fifo_head;

    hack_kbd_fifo #(
        .DEPTH (KBD_DEPTH)
    ) u_kbd_fifo (
        .clock (clock),
        .reset (reset),
        .push  (kbd_valid),
        .pop   (writeM && region == REG_KBD),
        .din   (kbd_code),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (fifo_head)
    );

    assign kbd_ready = !fifo_full;
    assign kbd_word  = fifo_empty ? 16'h0000 : fifo_head;
`else
    logic [15:0] key_reg;

    always_ff @(posedge clock) begin
        if (reset) begin
            key_reg <= '0;
        end else if (kbd_valid) begin
            key_reg <= kbd_code;
        end
    end

    assign kbd_ready = 1'b1;
    assign kbd_word  = key_reg;
`endif

endmodule

// File: tb/tb_hack_memory.sv
// Randomized scoreboard bench for hack_memory against a queue/array reference model.
module tb_hack_memory;

    localparam int KBD_DEPTH = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [14:0] addressM = '0;
    logic        writeM = 1'b0;
    logic [15:0] outM = '0;
    logic [15:0] inM;
    logic        kbd_valid = 1'b0;
    logic [15:0] kbd_code = '0;
    logic        kbd_ready;
    logic        scan_req = 1'b0;
    logic [12:0] scan_addr = '0;
    logic        scan_valid;
    logic [15:0] scan_data;
    logic        addr_err;

    hack_memory #(
        .RAM_WORDS    (16384),
        .SCREEN_WORDS (8192),
        .KBD_DEPTH    (KBD_DEPTH)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .addressM   (addressM),
        .writeM     (writeM),
        .outM       (outM),
        .inM        (inM),
        .kbd_valid  (kbd_valid),
        .kbd_code   (kbd_code),
        .kbd_ready  (kbd_ready),
        .scan_req   (scan_req),
        .scan_addr  (scan_addr),
        .scan_valid (scan_valid),
        .scan_data  (scan_data),
        .addr_err   (addr_err)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    always @(posedge clock) cyc++;

    // Reference model
    logic [15:0] ram_m [int];
    logic [15:0] scr_m [int];
    logic [15:0] kq [$];
    logic [15:0] key_m = '0;
    bit          aerr_m = 1'b0;

    typedef struct {
        logic [15:0] data;
        int          due;
    } scan_t;

    scan_t       scan_q [$];
    logic [15:0] rd_q [$];
    bit          rd_flag = 1'b0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit ready_m();
`ifdef HACK_KBD_FIFO_EN
        return kq.size() < KBD_DEPTH;
`else
        return 1'b1;
`endif
    endfunction

    function automatic logic [15:0] model_read(input logic [14:0] a);
        if (a < 15'h4000) return ram_m[int'(a)];
        if (a < 15'h6000) return scr_m[int'(a[12:0])];
        if (a == 15'h6000) begin
`ifdef HACK_KBD_FIFO_EN
            return (kq.size() > 0) ? kq[0] : 16'h0000;
`else
            return key_m;
`endif
        end
        return 16'h0000;
    endfunction

    // One clock of stimulus; expectations are captured from the pre-edge model.
    task automatic cycle(input bit wr, input logic [14:0] a, input logic [15:0] d,
                         input bit rd, input bit sc, input logic [12:0] sa,
                         input bit kv, input logic [15:0] kc, input bit rst);
        bit    rdy;
        scan_t s;
        writeM    = wr;
        addressM  = a;
        outM      = d;
        scan_req  = sc;
        scan_addr = sa;
        kbd_valid = kv;
        kbd_code  = kc;
        reset     = rst;
        rd_flag   = rd;
        if (rd) rd_q.push_back(model_read(a));
        if (sc && !rst) begin
            s.data = scr_m[int'(sa)];
            s.due  = cyc + 1;
            scan_q.push_back(s);
        end
        #2;
        rdy = ready_m();
        check("kbd_ready", {15'h0, kbd_ready}, {15'h0, rdy});
        check("addr_err", {15'h0, addr_err}, {15'h0, aerr_m});
        if (wr) begin
            if (a < 15'h4000) ram_m[int'(a)] = d;
            else if (a < 15'h6000) scr_m[int'(a[12:0])] = d;
            else if (a == 15'h6000) begin
`ifdef HACK_KBD_FIFO_EN
                if (kq.size() > 0) void'(kq.pop_front());
`endif
            end else if (!rst) aerr_m = 1'b1;
        end
        if (kv && rdy) begin
`ifdef HACK_KBD_FIFO_EN
            kq.push_back(kc);
`else
            key_m = kc;
`endif
        end
        if (rst) begin
            kq.delete();
            key_m  = '0;
            aerr_m = 1'b0;
        end
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        cycle(0, 15'h0, 16'h0, 0, 0, 13'h0, 0, 16'h0, 0);
    endtask

    task automatic wr_op(input logic [14:0] a, input logic [15:0] d);
        cycle(1, a, d, 0, 0, 13'h0, 0, 16'h0, 0);
    endtask

    task automatic rd_op(input logic [14:0] a);
        cycle(0, a, 16'h0, 1, 0, 13'h0, 0, 16'h0, 0);
    endtask

    task automatic push_key(input logic [15:0] k);
        cycle(0, 15'h0, 16'h0, 0, 0, 13'h0, 1, k, 0);
    endtask

    // Monitor: compares DUT outputs against queued expectations.
    always @(negedge clock) begin
        if (rd_flag) begin
            if (rd_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL inM no expectation queued (cycle %0d)", cyc);
            end else begin
                check("inM", inM, rd_q.pop_front());
            end
        end
        if (scan_valid === 1'b1) begin
            if (scan_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL scan_valid actual=1 expected=0 (cycle %0d)", cyc);
            end else begin
                scan_t e;
                e = scan_q.pop_front();
                check("scan_data", scan_data, e.data);
                check("scan_latency", cyc[15:0], e.due[15:0]);
            end
        end else if (scan_q.size() > 0 && scan_q[0].due <= cyc) begin
            checks++;
            failures++;
            $display("FAIL scan_valid actual=0 expected=1 (cycle %0d)", cyc);
            void'(scan_q.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [14:0] a;
        int          kind;

        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        #1;
        check("reset_scan_valid", {15'h0, scan_valid}, 16'h0);
        check("reset_scan_data", scan_data, 16'h0);
        check("reset_addr_err", {15'h0, addr_err}, 16'h0);
        @(posedge clock);
        #1;

        // Preload a working window so every model read has a defined value.
        for (int i = 0; i < 64; i++) wr_op(15'(i), 16'($urandom));
        for (int i = 0; i < 32; i++) wr_op(15'(16'h4000 + i), 16'($urandom));
        rd_op(15'h0011);

        wr_op(15'h0010, 16'h1234);
        rd_op(15'h0010);

        wr_op(15'h4005, 16'hFFFF);
        cycle(0, 15'h0, 16'h0, 0, 1, 13'd5, 0, 16'h0, 0);
        cycle(1, 15'h4005, 16'h0000, 1, 1, 13'd5, 0, 16'h0, 0);
        cycle(0, 15'h4005, 16'h0, 1, 1, 13'd5, 0, 16'h0, 0);
        idle();

        rd_op(15'h7000);
        rd_op(15'h6001);
        wr_op(15'h7000, 16'hBEEF);
        repeat (10) idle();
        cycle(0, 15'h0, 16'h0, 0, 0, 13'h0, 0, 16'h0, 1);
        idle();
        cycle(1, 15'h7FFF, 16'h1111, 0, 0, 13'h0, 0, 16'h0, 1);
        idle();

        // Keyboard: same stimulus exercises both the register and FIFO builds.
        push_key(16'h0041);
        rd_op(15'h6000);
        push_key(16'h0000);
        rd_op(15'h6000);
        wr_op(15'h6000, 16'h0);
        rd_op(15'h6000);
        push_key(16'h0041);
        push_key(16'h0042);
        push_key(16'h0043);
        push_key(16'h0044);
        push_key(16'h0045);
        rd_op(15'h6000);
        wr_op(15'h6000, 16'h0);
        rd_op(15'h6000);
        for (int i = 0; i < 4; i++) begin
            wr_op(15'h6000, 16'h0);
            rd_op(15'h6000);
        end
        cycle(1, 15'h6000, 16'h0, 1, 0, 13'h0, 1, 16'h0077, 0);
        rd_op(15'h6000);

        push_key(16'h0051);
        push_key(16'h0052);
        cycle(0, 15'h0, 16'h0, 0, 1, 13'd3, 0, 16'h0, 1);
        rd_op(15'h6000);
        rd_op(15'h0010);

        for (int n = 0; n < 400; n++) begin
            kind = $urandom_range(0, 9);
            if (kind < 5) a = 15'($urandom_range(0, 63));
            else if (kind < 8) a = 15'(16'h4000 + $urandom_range(0, 31));
            else if (kind == 8) a = 15'h6000;
            else a = 15'(16'h6001 + $urandom_range(0, 16'h1FFE));
            cycle(($urandom % 3) == 0, a, 16'($urandom), $urandom_range(0, 1) == 1,
                  $urandom_range(0, 1) == 1, 13'($urandom_range(0, 31)),
                  ($urandom % 3) == 0, 16'($urandom), $urandom_range(0, 49) == 0);
        end

        repeat (3) idle();
        check("scan_queue_drained", 16'(scan_q.size()), 16'h0);
        check("read_queue_drained", 16'(rd_q.size()), 16'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
